// File: rtl/ps2_host_tx_pkg.sv
// -----------------------------------------------------------------------------
// ps2_host_tx_pkg
//   Shared definitions for the PS/2 host-to-device transmitter.
//   - FSM state encoding
//   - err_code values reported with the error pulse
//   - default timing constants (50 MHz system clock)
//   - latched request frame type and odd-parity helper
// Optional feature macro used by the block: PS2_TX_RETRY_EN
// -----------------------------------------------------------------------------
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NACK    = 2'b10;

    // 100 us inhibit and 15 ms inter-edge timeout at 50 MHz
    localparam int DEF_INHIBIT_CYCLES = 5000;
    localparam int DEF_TIMEOUT_CYCLES = 750000;
    localparam int DEF_TO_W           = 20;

    // Number of device clock falls already seen when the fall that
    // releases data for the stop bit arrives (falls 1..9 carry d0..d7, parity).
    localparam logic [3:0] FALLS_BEFORE_STOP = 4'd9;

    // Byte as it goes on the wire after the start bit: LSB first, parity last.
    typedef struct packed {
        logic       parity;
        logic [7:0] data;
    } tx_frame_t;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// -----------------------------------------------------------------------------
// ps2_line_sync
//   Two-flop synchronisers for the raw PS/2 clock and data pad levels plus a
//   one-cycle pulse on each synchronised clock falling edge. Written so the
//   receive path can reuse it unchanged.
// Ports
//   clk          in   system clock
//   reset        in   asynchronous, active-low reset
//   ps2_clk_in   in   raw ps2_clk pad level (asynchronous)
//   ps2_data_in  in   raw ps2_data pad level (asynchronous)
//   clk_s        out  synchronised ps2_clk
//   data_s       out  synchronised ps2_data
//   clk_fall     out  1-cycle pulse on clk_s 1->0
// -----------------------------------------------------------------------------
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk_in,
    input  logic ps2_data_in,
    output logic clk_s,
    output logic data_s,
    output logic clk_fall
);

    logic [1:0] clk_pipe;
    logic [1:0] data_pipe;
    logic       clk_prev;

    // Flops reset to the idle (released, pulled-up) bus level so leaving reset
    // never fabricates a falling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_pipe  <= 2'b11;
            data_pipe <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_pipe  <= {clk_pipe[0], ps2_clk_in};
            data_pipe <= {data_pipe[0], ps2_data_in};
            clk_prev  <= clk_pipe[1];
        end
    end

    assign clk_s    = clk_pipe[1];
    assign data_s   = data_pipe[1];
    assign clk_fall = clk_prev & ~clk_pipe[1];

endmodule

// File: rtl/ps2_host_tx.sv
// -----------------------------------------------------------------------------
// ps2_host_tx
//   PS/2 host-to-device transmitter. Sends one command byte to the device over
//   the open-drain ps2_clk/ps2_data lines: inhibit, request-to-send, device
//   clocked shifting of d0..d7 + odd parity + stop, then ACK check and wait for
//   the bus to return idle.
// Parameters
//   INHIBIT_CYCLES  clk cycles ps2_clk is held low before the request
//   TIMEOUT_CYCLES  max clk cycles between device clock falling edges
//   TO_W            width of the shared inhibit/timeout counter
// Ports
//   clk, reset            system clock, asynchronous active-low reset
//   tx_data, tx_send      command byte and one-cycle request strobe
//   ps2_clk_in/data_in    raw pad levels
//   ps2_clk_oe/data_oe    1 = pull the line low, 0 = release
//   busy                  high from accepted request until done/error
//   done, error           one-cycle completion pulses
//   err_code              with error: 01 timeout, 10 no ACK
// Configuration
//   PS2_TX_RETRY_EN: when defined, the first failure silently restarts the
//   transfer from the inhibit phase with the same byte; only a second failure
//   raises error.
// -----------------------------------------------------------------------------
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int TO_W           = DEF_TO_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_send,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code
);

    localparam logic [TO_W-1:0] INH_LAST = TO_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] CNT_MAX  = {TO_W{1'b1}};

    logic clk_s, data_s, clk_fall;

    ps2_line_sync u_sync (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .clk_s       (clk_s),
        .data_s      (data_s),
        .clk_fall    (clk_fall)
    );

    state_t          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [3:0]      bitcnt_q, bitcnt_d;
    logic [8:0]      shreg_q, shreg_d;
    logic            clk_oe_q, clk_oe_d;
    logic            data_oe_q, data_oe_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic [1:0]      err_code_q, err_code_d;
`ifdef PS2_TX_RETRY_EN
    tx_frame_t       frame_q, frame_d;
    logic            retried_q, retried_d;
`endif

    logic            fail;
    logic [1:0]      fail_code;
    logic [TO_W-1:0] cnt_inc;
    tx_frame_t       req;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bitcnt_d   = bitcnt_q;
        shreg_d    = shreg_q;
        clk_oe_d   = clk_oe_q;
        data_oe_d  = data_oe_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        err_code_d = ERR_NONE;
`ifdef PS2_TX_RETRY_EN
        frame_d    = frame_q;
        retried_d  = retried_q;
`endif
        fail       = 1'b0;
        fail_code  = ERR_NONE;
        req        = '{parity: odd_parity(tx_data), data: tx_data};
        // Saturating so a stuck bus can never wrap the timeout back to zero.
        cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (tx_send) begin
                    shreg_d   = req;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    bitcnt_d  = '0;
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
                    state_d   = ST_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    frame_d   = req;
                    retried_d = 1'b0;
`endif
                end
            end

            ST_INHIBIT: begin
                cnt_d = cnt_inc;
                if (cnt_q == INH_LAST) begin
                    data_oe_d = 1'b1;      // start bit, clock still held low
                    state_d   = ST_REQ;
                end
            end

            // One cycle with both lines low, then hand the clock to the device.
            ST_REQ: begin
                clk_oe_d = 1'b0;
                cnt_d    = '0;
                bitcnt_d = '0;
                state_d  = ST_SHIFT;
            end

            // The device samples on its rising edge, so data only moves right
            // after a falling edge.
            ST_SHIFT: begin
                if (clk_fall) begin
                    cnt_d    = '0;
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == FALLS_BEFORE_STOP) begin
                        data_oe_d = 1'b0;  // stop bit = released line
                        state_d   = ST_ACK;
                    end else begin
                        data_oe_d = ~shreg_q[0];
                        shreg_d   = {1'b0, shreg_q[8:1]};
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_q >= TO_LAST) begin
                        fail      = 1'b1;
                        fail_code = ERR_TIMEOUT;
                    end
                end
            end

            ST_ACK: begin
                if (clk_fall) begin
                    cnt_d = '0;
                    if (data_s) begin
                        fail      = 1'b1;
                        fail_code = ERR_NACK;
                    end else begin
                        state_d = ST_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_q >= TO_LAST) begin
                        fail      = 1'b1;
                        fail_code = ERR_TIMEOUT;
                    end
                end
            end

            ST_WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (clk_fall) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_q >= TO_LAST) begin
                        fail      = 1'b1;
                        fail_code = ERR_TIMEOUT;
                    end
                end
            end

            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        if (fail) begin
`ifdef PS2_TX_RETRY_EN
            if (!retried_q) begin
                // Second chance: rerun the whole frame, caller sees nothing.
                retried_d = 1'b1;
                shreg_d   = frame_q;
                cnt_d     = '0;
                bitcnt_d  = '0;
                clk_oe_d  = 1'b1;
                data_oe_d = 1'b0;
                state_d   = ST_INHIBIT;
            end else
`endif
            begin
                clk_oe_d   = 1'b0;
                data_oe_d  = 1'b0;
                busy_d     = 1'b0;
                error_d    = 1'b1;
                err_code_d = fail_code;
                state_d    = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bitcnt_q   <= '0;
            shreg_q    <= '0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
`ifdef PS2_TX_RETRY_EN
            frame_q    <= '0;
            retried_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            clk_oe_q   <= clk_oe_d;
            data_oe_q  <= data_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
`ifdef PS2_TX_RETRY_EN
            frame_q    <= frame_d;
            retried_q  <= retried_d;
`endif
        end
    end

    // Pad enables come straight from flops so the open-drain lines never glitch.
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// -----------------------------------------------------------------------------
// tb_ps2_host_tx
//   Directed + randomized bench for ps2_host_tx with a behavioural PS/2 device
//   on a wired-AND bus. Timing parameters are scaled down to keep runs short.
// -----------------------------------------------------------------------------
module tb_ps2_host_tx;

    localparam int INH  = 200;
    localparam int TMO  = 3000;
    localparam int HALF = 20;      // device clock half period in clk cycles

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_send = 1'b0;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe, busy, done, error;
    logic [1:0] err_code;

    // Open-drain bus with pull-ups: low if anyone pulls.
    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .TO_W(20)) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_send     (tx_send),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_code    (err_code)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- bus activity monitor ----------------
    int         cyc = 0, done_cnt = 0, err_cnt = 0, inh_cnt = 0, dbl_done = 0;
    int         clk_oe_rise_cyc = 0, data_oe_first_cyc = 0, clk_oe_fall_cyc = 0, err_cyc = 0;
    logic [1:0] err_code_seen = 2'b00;
    logic       oe_at_err = 1'b0, busy_at_done = 1'b0;
    logic       prev_clk_oe = 1'b0, prev_data_oe = 1'b0, prev_done = 1'b0, want_data_rise = 1'b0;

    always @(negedge clk) begin
        cyc          <= cyc + 1;
        prev_clk_oe  <= ps2_clk_oe;
        prev_data_oe <= ps2_data_oe;
        prev_done    <= done;
        if (done) begin
            done_cnt     <= done_cnt + 1;
            busy_at_done <= busy;
            if (prev_done) dbl_done <= dbl_done + 1;
        end
        if (error) begin
            err_cnt       <= err_cnt + 1;
            err_code_seen <= err_code;
            oe_at_err     <= ps2_clk_oe | ps2_data_oe;
            err_cyc       <= cyc;
        end
        if (ps2_clk_oe && !prev_clk_oe) begin
            inh_cnt         <= inh_cnt + 1;
            clk_oe_rise_cyc <= cyc;
            want_data_rise  <= 1'b1;
        end
        if (ps2_data_oe && !prev_data_oe && want_data_rise) begin
            data_oe_first_cyc <= cyc;
            want_data_rise    <= 1'b0;
        end
        if (!ps2_clk_oe && prev_clk_oe) clk_oe_fall_cyc <= cyc;
    end

    // ---------------- checking / reference model ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wire frame as the device should see it: start, d0..d7, odd parity, stop.
    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        int          ones = 0;
        logic [10:0] f;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = b[i];
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        tx_data = b;
        tx_send = 1'b1;
        @(negedge clk);
        tx_send = 1'b0;
    endtask

    // Behavioural device: waits for request-to-send, clocks 11 pulses, samples
    // data on each rising edge, optionally ACKs. stop_fall>0 abandons with the
    // clock held low right after that fall; poke_fall>0 strobes tx_send with
    // 0x55 during that low phase.
    task automatic serve(input bit ack, input int stop_fall, input int poke_fall,
                         output logic [10:0] frame, output bit ok);
        int w = 0;
        frame = '0;
        ok    = 1'b0;
        while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && w < 4 * INH + 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 4 * INH + 100) return;
        repeat (10) @(negedge clk);
        frame[0] = ps2_data_in;
        for (int k = 1; k <= 11; k++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            if (k == poke_fall) begin
                tx_data = 8'h55;
                tx_send = 1'b1;
                @(negedge clk);
                tx_send = 1'b0;
            end
            if (k == stop_fall) begin
                ok = 1'b1;
                return;
            end
            dev_clk_low = 1'b0;
            if (k <= 10) frame[k] = ps2_data_in;
            if (k == 10 && ack) dev_data_low = 1'b1;
            if (k == 11) dev_data_low = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        ok = 1'b1;
    endtask

    task automatic wait_not_busy(input string tag);
        int w = 0;
        while (busy !== 1'b0 && w < 2 * (INH + TMO) + 2000) begin
            @(negedge clk);
            w++;
        end
        chk(tag, 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] b, input int poke, input string tag,
                        output logic [10:0] frame);
        int d0, e0, i0;
        bit ok;
        d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt;
        send(b);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        serve(1'b1, 0, poke, frame, ok);
        chk({tag, "_served"}, 32'(ok), 32'd1);
        wait_not_busy({tag, "_idle"});
        chk({tag, "_frame"}, 32'(frame), 32'(exp_frame(b)));
        chk({tag, "_done"}, done_cnt - d0, 32'd1);
        chk({tag, "_noerr"}, err_cnt - e0, 32'd0);
        chk({tag, "_inhibits"}, inh_cnt - i0, 32'd1);
        chk({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] frame;
        logic [7:0]  b;
        int          d0, e0, i0;
        bit          ok;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_clk_oe",  32'(ps2_clk_oe),  32'd0);
        chk("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        chk("rst_busy",    32'(busy),        32'd0);
        chk("rst_done",    32'(done),        32'd0);
        chk("rst_error",   32'(error),       32'd0);
        chk("rst_errcode", 32'(err_code),    32'd0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // 0xED: bits 1,0,1,1,0,1,1,1 then parity 1
        xfer(8'hED, 0, "ed", frame);
        chk("ed_parity", 32'(frame[9]), 32'd1);

        // 0xF4: inhibit length and one-cycle REQ overlap, parity 0
        xfer(8'hF4, 0, "f4", frame);
        chk("f4_parity", 32'(frame[9]), 32'd0);
        chk("f4_inhibit_len", data_oe_first_cyc - clk_oe_rise_cyc, INH);
        chk("f4_req_len", clk_oe_fall_cyc - data_oe_first_cyc, 32'd1);

        // Random bytes
        for (int r = 0; r < 4; r++) begin
            b = 8'($urandom_range(0, 255));
            xfer(b, 0, "rand", frame);
        end

        // Request while busy is ignored
        b = 8'($urandom_range(0, 255));
        if (b == 8'h55) b = 8'hAA;
        xfer(b, 3, "busy_ign", frame);
        repeat (50) @(negedge clk);
        chk("busy_ign_quiet", 32'(busy), 32'd0);

        // NACK
        d0 = done_cnt; e0 = err_cnt;
        send(8'hA5);
        serve(1'b0, 0, 0, frame, ok);
`ifdef PS2_TX_RETRY_EN
        serve(1'b0, 0, 0, frame, ok);
`endif
        chk("nack_served", 32'(ok), 32'd1);
        wait_not_busy("nack_idle");
        chk("nack_err", err_cnt - e0, 32'd1);
        chk("nack_code", 32'(err_code_seen), 32'd2);
        chk("nack_oe_released", 32'(oe_at_err), 32'd0);
        chk("nack_no_done", done_cnt - d0, 32'd0);

        // Timeout: device never clocks
        d0 = done_cnt; e0 = err_cnt;
        send(8'h0F);
        wait_not_busy("tmo_idle");
        chk("tmo_err", err_cnt - e0, 32'd1);
        chk("tmo_code", 32'(err_code_seen), 32'd1);
        chk("tmo_delay", err_cyc - clk_oe_fall_cyc, TMO);
        chk("tmo_oe_released", 32'(oe_at_err), 32'd0);
        chk("tmo_no_done", done_cnt - d0, 32'd0);

        // Reset mid-transfer after d4 is on the bus
        d0 = done_cnt; e0 = err_cnt;
        send(8'h3C);
        serve(1'b1, 5, 0, frame, ok);
        chk("mid_reached", 32'(ok), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_clk_oe",  32'(ps2_clk_oe),  32'd0);
        chk("mid_data_oe", 32'(ps2_data_oe), 32'd0);
        chk("mid_busy",    32'(busy),        32'd0);
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid_no_done", done_cnt - d0, 32'd0);
        chk("mid_no_err",  err_cnt - e0,  32'd0);
        xfer(8'hED, 0, "after_rst", frame);

`ifdef PS2_TX_RETRY_EN
        // First attempt NACKed, retry ACKed
        d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt;
        send(8'h5A);
        serve(1'b0, 0, 0, frame, ok);
        serve(1'b1, 0, 0, frame, ok);
        chk("retry_served", 32'(ok), 32'd1);
        wait_not_busy("retry_idle");
        chk("retry_frame", 32'(frame), 32'(exp_frame(8'h5A)));
        chk("retry_done", done_cnt - d0, 32'd1);
        chk("retry_noerr", err_cnt - e0, 32'd0);
        chk("retry_inhibits", inh_cnt - i0, 32'd2);
`endif

        chk("done_single_cycle", dbl_done, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
